// File: rtl/imsic_msi_sender.sv
// MSI queue and delivery serializer feeding the per-hart IMSIC CSR gate.
// Optional build macro IMSIC_MSI_DROP_CNT_EN adds a saturating illegal-message drop counter.
module imsic_msi_sender #(
  parameter int NR_INTP_FILES  = 7,
  parameter int NR_HARTS       = 4,
  parameter int NR_HARTS_WIDTH = 2,
  parameter int NR_SRC         = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int VLD_HIGH_CYC   = 4,
  parameter int INFO_HOLD_CYC  = 8,
  localparam int NR_SRC_WIDTH    = $clog2(NR_SRC),
  localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
  localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_msi_vld,
  output logic                       o_msi_rdy,
  input  logic [NR_HARTS_WIDTH-1:0]  i_msi_hart,
  input  logic [INTP_FILE_WIDTH-1:0] i_msi_file,
  input  logic [NR_SRC_WIDTH-1:0]    i_msi_data,
  output logic [MSI_INFO_WIDTH-1:0]  o_msi_info,
  output logic                       o_msi_info_vld,
  output logic                       o_busy
`ifdef IMSIC_MSI_DROP_CNT_EN
  ,
  input  logic                       i_drop_cnt_clr,
  output logic [15:0]                o_drop_cnt
`endif
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (VLD_HIGH_CYC > INFO_HOLD_CYC) ? VLD_HIGH_CYC : INFO_HOLD_CYC;
  localparam int TMR_W   = $clog2(CNT_MAX + 1);
  localparam logic [31:0] HARTS_LIM = NR_HARTS;
  localparam logic [31:0] FILES_LIM = NR_INTP_FILES;
  localparam logic [31:0] SRC_LIM   = NR_SRC;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  logic [MSI_INFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [PTR_W:0]            r_count;
  state_t                    r_state;
  logic [TMR_W-1:0]          r_tmr;
  logic [MSI_INFO_WIDTH-1:0] r_info;
  logic                      r_info_vld;

  logic [31:0] w_hart_ext;
  logic [31:0] w_file_ext;
  logic [31:0] w_data_ext;
  logic        w_legal;
  logic        w_full;
  logic        w_empty;
  logic        w_hs;
  logic        w_push;
  logic        w_pop;
  logic        w_vld_done;
  logic        w_hold_done;

  // Range checks run on zero-extended copies so any parameter choice compares cleanly.
  assign w_hart_ext = {{(32-NR_HARTS_WIDTH){1'b0}}, i_msi_hart};
  assign w_file_ext = {{(32-INTP_FILE_WIDTH){1'b0}}, i_msi_file};
  assign w_data_ext = {{(32-NR_SRC_WIDTH){1'b0}}, i_msi_data};
  assign w_legal    = (w_hart_ext < HARTS_LIM) & (w_file_ext < FILES_LIM) &
                      (w_data_ext != 32'd0) & (w_data_ext < SRC_LIM);

  assign w_full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == {(PTR_W+1){1'b0}});
  assign o_msi_rdy   = ~rst & ~w_full;
  assign w_hs        = i_msi_vld & o_msi_rdy;
  assign w_push      = w_hs & w_legal;
  assign w_vld_done  = (r_tmr == TMR_W'(VLD_HIGH_CYC));
  assign w_hold_done = (r_tmr == TMR_W'(INFO_HOLD_CYC));
  assign w_pop       = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_HOLD) & w_hold_done));

  // Message storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_msi_hart, i_msi_file, i_msi_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Delivery envelope: info loads only on a pop edge and holds across vld high and the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tmr      <= {TMR_W{1'b0}};
      r_info     <= {MSI_INFO_WIDTH{1'b0}};
      r_info_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_info     <= r_mem[r_rd_ptr];
            r_info_vld <= 1'b1;
            r_state    <= S_ASSERT;
            r_tmr      <= TMR_W'(1);
          end
        end
        S_ASSERT: begin
          if (w_vld_done) begin
            r_info_vld <= 1'b0;
            r_state    <= S_HOLD;
            r_tmr      <= TMR_W'(1);
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        S_HOLD: begin
          if (w_pop) begin
            r_info     <= r_mem[r_rd_ptr];
            r_info_vld <= 1'b1;
            r_state    <= S_ASSERT;
            r_tmr      <= TMR_W'(1);
          end else if (w_hold_done) begin
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_info_vld <= 1'b0;
        end
      endcase
    end
  end

  assign o_msi_info     = r_info;
  assign o_msi_info_vld = r_info_vld;
  assign o_busy         = ~w_empty | (r_state != S_IDLE);

`ifdef IMSIC_MSI_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating count of consumed-but-illegal messages; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 16'd0;
    end else if (i_drop_cnt_clr) begin
      r_drop_cnt <= 16'd0;
    end else if (w_hs & ~w_legal & (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

endmodule
